// File: rtl/sr595_frame_receiver.sv
// Receive side of a 74HC595 SCLK/DATA/LATCH link: oversamples the pins with clk and
// rebuilds the latched word of a NUM_ICS-deep 595 chain, flagging bad-length frames.
module sr595_frame_receiver #(
  parameter int NUM_ICS     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sclk_i,
  input  logic                   data_i,
  input  logic                   latch_i,
  output logic [8*NUM_ICS-1:0]   word_o,
  output logic                   word_valid_o,
  output logic                   frame_err_o,
  output logic [15:0]            frame_cnt_o,
  output logic                   busy_o
);

  localparam int W  = 8 * NUM_ICS;
  localparam int CW = $clog2(W + 2);

  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, data_sync, latch_sync;
  logic                   sclk_hist, latch_hist;
  logic                   sclk_rise_q, latch_rise_q;
  logic                   data_d;
  logic [W-1:0]           shreg;
  logic [CW-1:0]          bit_cnt;

  // Equal-depth synchronizers keep data aligned with sclk; the edge pulses and the
  // matching data sample are registered once more so all three stay in lock-step.
  // NOTE: synchronizer and history flops are reset too, so a pin that is already high
  // when reset releases is seen as a fresh rising edge rather than silently ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync    <= '0;
      data_sync    <= '0;
      latch_sync   <= '0;
      sclk_hist    <= 1'b0;
      latch_hist   <= 1'b0;
      sclk_rise_q  <= 1'b0;
      latch_rise_q <= 1'b0;
      data_d       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage of the chain sample the value
      // its predecessor held before this edge; blocking would collapse the chain.
      sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      data_sync    <= {data_sync[SYNC_STAGES-2:0], data_i};
      latch_sync   <= {latch_sync[SYNC_STAGES-2:0], latch_i};
      sclk_hist    <= sclk_sync[SYNC_STAGES-1];
      latch_hist   <= latch_sync[SYNC_STAGES-1];
      sclk_rise_q  <= sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
      latch_rise_q <= latch_sync[SYNC_STAGES-1] & ~latch_hist;
      data_d       <= data_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A shift edge always leaves us in SHIFT, even when it coincides with a latch.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (sclk_rise_q) begin
      state_d = SHIFT;
    end else if (latch_rise_q) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    busy_o = (state_q == SHIFT);
  end

  // Latch samples shreg before any coincident shift, like a 595 with tied clocks;
  // shreg itself is never cleared by a latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      word_o       <= '0;
      word_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      word_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;

      if (latch_rise_q) begin
        word_o       <= shreg;
        word_valid_o <= 1'b1;
        if (bit_cnt == CNT_FULL) begin
          frame_cnt_o <= frame_cnt_o + 16'd1;
        end else begin
          frame_err_o <= 1'b1;
        end
      end

      if (sclk_rise_q) begin
        shreg <= {shreg[W-2:0], data_d};
        if (latch_rise_q) begin
          bit_cnt <= CW'(1);
        end else if (bit_cnt != CNT_SAT) begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end else if (latch_rise_q) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sr595_frame_receiver.sv
// Directed bench for sr595_frame_receiver: drives the 595 link pins with safe timing
// and compares latched words, pulses and the good-frame counter with hand values.
module tb_sr595_frame_receiver;

  localparam int H = 4;  // clk periods per pin level, above SYNC_STAGES+1

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk_i = 1'b0;
  logic        data_i = 1'b0;
  logic        latch_i = 1'b0;
  logic [15:0] word_o;
  logic        word_valid_o;
  logic        frame_err_o;
  logic [15:0] frame_cnt_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  int          valid_cnt = 0;
  int          err_cnt   = 0;
  logic        last_err  = 1'b0;
  int          v0, e0;

  sr595_frame_receiver #(.NUM_ICS(2), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk_i       (sclk_i),
    .data_i       (data_i),
    .latch_i      (latch_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .frame_err_o  (frame_err_o),
    .frame_cnt_o  (frame_cnt_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_valid_o) begin
      valid_cnt = valid_cnt + 1;
      last_err  = frame_err_o;
    end
    if (frame_err_o) err_cnt = err_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    data_i = b;
    wait_clk(H);
    sclk_i = 1'b1;
    wait_clk(H);
    sclk_i = 1'b0;
    wait_clk(H);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic latch_pulse();
    latch_i = 1'b1;
    wait_clk(H);
    latch_i = 1'b0;
    wait_clk(2 * H);
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    v0 = valid_cnt;
    send_bits(v, n);
    latch_pulse();
  endtask

  logic [15:0] loop_words [4] = '{16'h3F06, 16'h5B4F, 16'h6D7D, 16'h077F};

  initial begin
    // Reset state
    wait_clk(3);
    check("rst_word", word_o, 0);
    check("rst_valid", word_valid_o, 0);
    check("rst_err", frame_err_o, 0);
    check("rst_cnt", frame_cnt_o, 0);
    check("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    wait_clk(2);

    // Good frame 0xA5C3, busy after the first bit
    v0 = valid_cnt;
    send_bit(1'b1);
    check("busy_shift", busy_o, 1);
    send_bits(32'h25C3, 15);
    latch_pulse();
    check("a5c3_word", word_o, 16'hA5C3);
    check("a5c3_pulses", valid_cnt - v0, 1);
    check("a5c3_err", last_err, 0);
    check("a5c3_cnt", frame_cnt_o, 1);
    check("a5c3_busy", busy_o, 0);

    // Short frame: 15 bits 0x0F0F after 0xA5C3 leaves shreg = 0x8F0F
    frame(32'h0F0F, 15);
    check("short_word", word_o, 16'h8F0F);
    check("short_pulses", valid_cnt - v0, 1);
    check("short_err", last_err, 1);
    check("short_cnt", frame_cnt_o, 1);

    // Long frame: 17 bits, last 16 = 0xBEEF
    frame(32'h1BEEF, 17);
    check("long_word", word_o, 16'hBEEF);
    check("long_err", last_err, 1);
    check("long_cnt", frame_cnt_o, 1);
    check("long_busy", busy_o, 0);

    // 0x1234, then coincident sclk/latch rise carrying first bit of 0xC0DE
    v0 = valid_cnt;
    send_bits(32'h1234, 16);
    data_i = 1'b1;
    wait_clk(H);
    sclk_i  = 1'b1;
    latch_i = 1'b1;
    wait_clk(H);
    sclk_i  = 1'b0;
    latch_i = 1'b0;
    wait_clk(H);
    check("coinc_word", word_o, 16'h1234);
    check("coinc_pulses", valid_cnt - v0, 1);
    check("coinc_err", last_err, 0);
    check("coinc_cnt", frame_cnt_o, 2);
    check("coinc_busy", busy_o, 1);
    frame(32'h40DE, 15);
    check("c0de_word", word_o, 16'hC0DE);
    check("c0de_err", last_err, 0);
    check("c0de_cnt", frame_cnt_o, 3);

    // Reset mid-frame
    send_bits(32'hAA, 8);
    v0 = valid_cnt;
    rst_n = 1'b0;
    wait_clk(4);
    check("midrst_word", word_o, 0);
    check("midrst_cnt", frame_cnt_o, 0);
    check("midrst_busy", busy_o, 0);
    rst_n = 1'b1;
    wait_clk(2 * H);
    check("midrst_nopulse", valid_cnt - v0, 0);
    frame(32'hFFFF, 16);
    check("ffff_word", word_o, 16'hFFFF);
    check("ffff_pulses", valid_cnt - v0, 1);
    check("ffff_err", last_err, 0);
    check("ffff_cnt", frame_cnt_o, 1);

    // Counter wrap
    force dut.frame_cnt_o = 16'hFFFF;
    wait_clk(1);
    release dut.frame_cnt_o;
    wait_clk(1);
    check("preload_cnt", frame_cnt_o, 16'hFFFF);
    frame(32'h0001, 16);
    check("wrap_word", word_o, 16'h0001);
    check("wrap_cnt", frame_cnt_o, 0);

    // Transmitter-style refreshes of four digit words
    e0 = err_cnt;
    for (int k = 0; k < 4; k++) begin
      frame({16'h0, loop_words[k]}, 16);
      check($sformatf("loop%0d_word", k), word_o, loop_words[k]);
      check($sformatf("loop%0d_pulses", k), valid_cnt - v0, 1);
    end
    check("loop_errs", err_cnt - e0, 0);
    check("loop_cnt", frame_cnt_o, 4);

    // Static pins hold outputs
    wait_clk(50);
    check("hold_word", word_o, 16'h077F);
    check("hold_cnt", frame_cnt_o, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
